// File: rtl/aq_ifu_ibuf_pop_ctrl_if.sv
// IFU ibuf to IDU instruction handoff: registered instruction, side-band info and ready.
// Handshake: an instruction transfers on a cycle where ibuf_idu_inst_vld and idu_ibuf_ready are
// both 1; while vld is 1 and ready is 0 every payload signal stays stable.
interface aq_ifu_ibuf_pop_ctrl_if #(
    parameter int HINFO_W = 22
);
    logic               ibuf_idu_inst_vld;
    logic [31:0]        ibuf_idu_inst;
    logic               ibuf_idu_inst_32;
    logic [1:0]         ibuf_idu_pred_taken;
    logic [HINFO_W-1:0] ibuf_idu_halt_info;
    logic               ibuf_idu_expt_vld;
    logic               ibuf_idu_expt_pgflt;
    logic               ibuf_idu_expt_hi;
    logic               idu_ibuf_ready;

    modport master (
        output ibuf_idu_inst_vld, ibuf_idu_inst, ibuf_idu_inst_32, ibuf_idu_pred_taken,
               ibuf_idu_halt_info, ibuf_idu_expt_vld, ibuf_idu_expt_pgflt, ibuf_idu_expt_hi,
        input  idu_ibuf_ready
    );

    modport slave (
        input  ibuf_idu_inst_vld, ibuf_idu_inst, ibuf_idu_inst_32, ibuf_idu_pred_taken,
               ibuf_idu_halt_info, ibuf_idu_expt_vld, ibuf_idu_expt_pgflt, ibuf_idu_expt_hi,
        output idu_ibuf_ready
    );
endinterface

// File: rtl/aq_ifu_ibuf_pop_ctrl.sv
// Read side of the IFU instruction buffer: assembles RVC/32-bit instructions from the
// halfword ring at the read pointer, retires consumed entries, and registers them for the IDU.
module aq_ifu_ibuf_pop_ctrl #(
    parameter int ENTRY_NUM = 8,
    parameter int PTR_W     = 3,
    parameter int HINFO_W   = 22
) (
    input  logic                         ibuf_cpuclk,
    input  logic                         cpurst_b,
    input  logic                         ibuf_flush_en,
    input  logic [ENTRY_NUM-1:0]         ibuf_entry_vld,
    input  logic [16*ENTRY_NUM-1:0]      ibuf_entry_inst,
    input  logic [2*ENTRY_NUM-1:0]       ibuf_entry_pred_taken,
    input  logic [HINFO_W*ENTRY_NUM-1:0] ibuf_entry_halt_info,
    input  logic [ENTRY_NUM-1:0]         ibuf_entry_acc_err,
    input  logic [ENTRY_NUM-1:0]         ibuf_entry_pgflt,
    output logic [ENTRY_NUM-1:0]         ibuf_entry_retire_en,
    output logic [PTR_W-1:0]             ibuf_pop_rptr_dbg,
    aq_ifu_ibuf_pop_ctrl_if.master       idu_if
);

    logic [PTR_W-1:0]   rptr;
    logic [PTR_W-1:0]   nptr;
    logic [15:0]        head_inst;
    logic [15:0]        next_inst;
    logic [1:0]         head_pred;
    logic [HINFO_W-1:0] head_hinfo;
    logic               is32;
    logic               herr;
    logic               nerr;
    logic               pair;
    logic               cand;
    logic               load;

    logic               out_vld;
    logic [31:0]        out_inst;
    logic               out_inst_32;
    logic [1:0]         out_pred;
    logic [HINFO_W-1:0] out_hinfo;
    logic               out_expt_vld;
    logic               out_expt_pgflt;
    logic               out_expt_hi;

    // next wraps N-1 -> 0 because the pointer is exactly log2(ENTRY_NUM) bits wide
    assign nptr       = rptr + PTR_W'(1);
    assign head_inst  = ibuf_entry_inst[16*rptr +: 16];
    assign next_inst  = ibuf_entry_inst[16*nptr +: 16];
    assign head_pred  = ibuf_entry_pred_taken[2*rptr +: 2];
    assign head_hinfo = ibuf_entry_halt_info[HINFO_W*rptr +: HINFO_W];

    assign is32 = (head_inst[1:0] == 2'b11);
    assign herr = ibuf_entry_acc_err[rptr] | ibuf_entry_pgflt[rptr];
    assign nerr = ibuf_entry_acc_err[nptr] | ibuf_entry_pgflt[nptr];

    // A faulting head pops alone as a 16-bit slot instead of waiting for its upper half
    assign pair = is32 & ~herr;
    assign cand = ibuf_entry_vld[rptr] & (~is32 | herr | ibuf_entry_vld[nptr]);
    // cpurst_b gating keeps the retire strobe quiet while reset is held
    assign load = cand & (~out_vld | idu_if.idu_ibuf_ready) & ~ibuf_flush_en & cpurst_b;

    always_comb begin
        ibuf_entry_retire_en = '0;
        if (load) begin
            ibuf_entry_retire_en[rptr] = 1'b1;
            if (pair) begin
                ibuf_entry_retire_en[nptr] = 1'b1;
            end
        end
    end

    always_ff @(posedge ibuf_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rptr <= '0;
        end else if (ibuf_flush_en) begin
            rptr <= '0;
        end else if (load) begin
            rptr <= rptr + (pair ? PTR_W'(2) : PTR_W'(1));
        end
    end

    always_ff @(posedge ibuf_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            out_vld <= 1'b0;
        end else if (ibuf_flush_en) begin
            out_vld <= 1'b0;
        end else if (load) begin
            out_vld <= 1'b1;
        end else if (idu_if.idu_ibuf_ready) begin
            out_vld <= 1'b0;
        end
    end

    always_ff @(posedge ibuf_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            out_inst       <= '0;
            out_inst_32    <= 1'b0;
            out_pred       <= '0;
            out_hinfo      <= '0;
            out_expt_vld   <= 1'b0;
            out_expt_pgflt <= 1'b0;
            out_expt_hi    <= 1'b0;
        end else if (load) begin
            out_inst       <= pair ? {next_inst, head_inst} : {16'b0, head_inst};
            out_inst_32    <= is32;
            out_pred       <= head_pred;
            out_hinfo      <= head_hinfo;
            out_expt_vld   <= herr | (is32 & nerr);
            // head fault wins; the upper-half fault only counts when the head is clean
            out_expt_pgflt <= ibuf_entry_pgflt[rptr] | (pair & ibuf_entry_pgflt[nptr]);
            out_expt_hi    <= pair & nerr;
        end
    end

    assign ibuf_pop_rptr_dbg          = rptr;
    assign idu_if.ibuf_idu_inst_vld   = out_vld;
    assign idu_if.ibuf_idu_inst       = out_inst;
    assign idu_if.ibuf_idu_inst_32    = out_inst_32;
    assign idu_if.ibuf_idu_pred_taken = out_pred;
    assign idu_if.ibuf_idu_halt_info  = out_hinfo;
    assign idu_if.ibuf_idu_expt_vld   = out_expt_vld;
    assign idu_if.ibuf_idu_expt_pgflt = out_expt_pgflt;
    assign idu_if.ibuf_idu_expt_hi    = out_expt_hi;

endmodule
